alu_ctl_sequencer: RTL and testbench
====================================

// Module: alu_ctl_sequencer
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle ALU control decode.
//  - Decodes alu_op/funct into a registered alu_ctl command for the datapath ALU.
//  - Expands multi-bit rotates (ROL/ROR by shamt) into a stream of 1-bit rotate beats.
//  - Flags undefined funct codes.
//  - Sits between the main control unit / instruction register and the ALU.
// PARAMETERS
//  ALU_OP_W   2   width of alu_op; MSB set = R-type
//  FUNCT_W    6   width of funct field
//  CTL_W      3   width of alu_ctl command
//  SHAMT_W    5   width of rotate amount; max beats = 2**SHAMT_W-1
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         reset, asynchronous assert, active-low
//  in_valid   in   1         request valid
//  in_ready   out  1         request accepted when in_valid && in_ready
//  alu_op     in   ALU_OP_W  ALU operation class
//  funct      in   FUNCT_W   R-type function code
//  shamt      in   SHAMT_W   rotate amount (ROL/ROR only; ignored otherwise)
//  ctl_valid  out  1         alu_ctl beat valid
//  ctl_ready  in   1         ALU consumes beat when ctl_valid && ctl_ready
//  alu_ctl    out  CTL_W     ALU command
//  ctl_last   out  1         current beat is the final beat of the request
//  illegal    out  1         one-cycle pulse: accepted request had an undefined funct
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low.
//   rst_n low -> state IDLE; ctl_valid=0, alu_ctl=0, ctl_last=0, illegal=0, beat counter=0.
//   Asserting rst_n mid-stream abandons remaining beats; no beat is issued after release
//   until a new request is accepted.
//  Decode:
//   alu_op MSB=0: low bit 0 -> ADD 3'b010 (LW/SW); low bit 1 -> SUB 3'b110 (BEQ).
//   alu_op MSB=1, funct:
//    100000 -> ADD 010    100001 -> ROL 100    100010 -> SUB 110
//    100011 -> ROR 101    100100 -> AND 000    100101 -> OR  001
//    any other -> illegal.
//  Beat count:
//   ROL/ROR: max(shamt,1) beats; shamt==0 is treated as 1.
//   All other legal ops: 1 beat.
//  FSM:
//   IDLE: ctl_valid=0.
//    Accept legal request -> load alu_ctl and remaining=beats; ctl_last=(beats==1); go BEAT.
//    Accept illegal request -> illegal=1 next cycle; stay IDLE; alu_ctl holds previous value.
//   BEAT: ctl_valid=1.
//    Handshake && !ctl_last -> remaining--; ctl_last=(remaining==2 before decrement).
//    Handshake && ctl_last -> IDLE, or reload BEAT if a new legal request is accepted
//    in the same cycle.
//  Handshake:
//   in_ready = !ctl_valid || (ctl_ready && ctl_last); a combinational path
//   ctl_ready->in_ready is permitted.
//   Latency: request accepted in cycle N -> first beat valid in cycle N+1.
//   Back-to-back single-beat ops sustain 1 beat/cycle.
//   While ctl_valid && !ctl_ready: alu_ctl, ctl_last and ctl_valid are held stable.
//   in_valid with in_ready low: no effect; alu_op/funct/shamt are sampled only on acceptance.
//  Illegal pulse: exactly one cycle per illegal request. An illegal request accepted on
//   the final beat handshake ends the stream (state -> IDLE) and pulses illegal.
// STRUCTURE
//  Package alu_ctl_pkg:
//   - alu_ctl_e enum: AND, OR, ADD, ROL, ROR, SUB codes above.
//   - FUNCT_* localparams.
//   - seq_state_e {IDLE, BEAT}.
//  Sub-module alu_ctl_decode (combinational): alu_op, funct -> ctl, is_rotate, legal.
//  Top level holds the FSM, beat counter, output registers and illegal flop.
// TESTING
//  1. Reset mid-BEAT (ROL shamt=7, after beat 3) -> ctl_valid=0 immediately;
//     no further beats after release.
//  2. alu_op=00, ctl_ready=1 -> one beat, alu_ctl=010, ctl_last=1, valid in cycle N+1.
//  3. R-type funct=100011, shamt=4, ctl_ready=1 -> 4 beats alu_ctl=101; ctl_last only on
//     beat 4; in_ready low for beats 1-3.
//  4. ROL shamt=3 with ctl_ready toggled 1,0,0,1,1 -> 3 beats, outputs stable while stalled.
//  5. funct=101010 -> illegal high for exactly 1 cycle; ctl_valid stays 0; next ADD issues normally.
//  6. Stream ADD,SUB,AND,OR back-to-back, ctl_ready=1 -> 010,110,000,001 on 4 consecutive
//     cycles; shamt=0 ROL -> 1 beat.

Source files
------------

// File: rtl/alu_ctl_pkg.sv
// Shared types and constants for the ALU control sequencer.
// The command encodings match what the datapath ALU expects on alu_ctl.
package alu_ctl_pkg;

    localparam int unsigned CTL_ENUM_W = 3;

    typedef enum logic [CTL_ENUM_W-1:0] {
        CTL_AND = 3'b000,
        CTL_OR  = 3'b001,
        CTL_ADD = 3'b010,
        CTL_ROL = 3'b100,
        CTL_ROR = 3'b101,
        CTL_SUB = 3'b110
    } alu_ctl_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_ROL = 6'b100001;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_ROR = 6'b100011;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    typedef enum logic {
        IDLE,
        BEAT
    } seq_state_e;

    function automatic logic is_rotate_ctl(input alu_ctl_e c);
        return (c == CTL_ROL) || (c == CTL_ROR);
    endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of alu_op/funct into an ALU command.
// legal is low only for R-type requests carrying an undefined funct.
module alu_ctl_decode
    import alu_ctl_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned FUNCT_W  = 6
) (
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0]  funct,
    output alu_ctl_e            ctl,
    output logic                is_rotate,
    output logic                legal
);

    always_comb begin
        ctl   = CTL_ADD;
        legal = 1'b1;
        if (!alu_op[ALU_OP_W-1]) begin
            ctl = alu_op[0] ? CTL_SUB : CTL_ADD;
        end else begin
            case (funct)
                FUNCT_W'(FUNCT_ADD): ctl = CTL_ADD;
                FUNCT_W'(FUNCT_ROL): ctl = CTL_ROL;
                FUNCT_W'(FUNCT_SUB): ctl = CTL_SUB;
                FUNCT_W'(FUNCT_ROR): ctl = CTL_ROR;
                FUNCT_W'(FUNCT_AND): ctl = CTL_AND;
                FUNCT_W'(FUNCT_OR):  ctl = CTL_OR;
                default: begin
                    ctl   = CTL_ADD;
                    legal = 1'b0;
                end
            endcase
        end
        is_rotate = legal && is_rotate_ctl(ctl);
    end

endmodule

// File: rtl/alu_ctl_sequencer.sv
// Handshaked ALU control sequencer: registers decoded commands and expands
// multi-bit rotates into a stream of 1-bit rotate beats.
module alu_ctl_sequencer
    import alu_ctl_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned CTL_W    = 3,
    parameter int unsigned SHAMT_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [SHAMT_W-1:0]  shamt,
    output logic                ctl_valid,
    input  logic                ctl_ready,
    output logic [CTL_W-1:0]    alu_ctl,
    output logic                ctl_last,
    output logic                illegal
);

    seq_state_e         state_q, state_d;
    logic [CTL_W-1:0]   alu_ctl_q, alu_ctl_d;
    logic               ctl_last_q, ctl_last_d;
    logic               illegal_q, illegal_d;
    logic [SHAMT_W-1:0] remaining_q, remaining_d;

    alu_ctl_e           dec_ctl;
    logic               dec_is_rotate;
    logic               dec_legal;
    logic [SHAMT_W-1:0] req_beats;
    logic               accept;
    logic               handshake;

    alu_ctl_decode #(
        .ALU_OP_W (ALU_OP_W),
        .FUNCT_W  (FUNCT_W)
    ) u_decode (
        .alu_op    (alu_op),
        .funct     (funct),
        .ctl       (dec_ctl),
        .is_rotate (dec_is_rotate),
        .legal     (dec_legal)
    );

    // A zero rotate amount still issues one beat.
    assign req_beats = (dec_is_rotate && (shamt != '0)) ? shamt : SHAMT_W'(1);
    assign accept    = in_valid && in_ready;
    assign handshake = ctl_valid && ctl_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_ctl_q   <= '0;
            ctl_last_q  <= 1'b0;
            illegal_q   <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            alu_ctl_q   <= alu_ctl_d;
            ctl_last_q  <= ctl_last_d;
            illegal_q   <= illegal_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && dec_legal) state_d = BEAT;
            BEAT: if (handshake && ctl_last_q) state_d = (accept && dec_legal) ? BEAT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctl_valid = (state_q == BEAT);
        in_ready  = !ctl_valid || (ctl_ready && ctl_last_q);
        alu_ctl   = alu_ctl_q;
        ctl_last  = ctl_last_q;
        illegal   = illegal_q;
    end

    // Acceptance while busy can only coincide with the final-beat handshake,
    // so a new legal request simply overwrites the beat registers.
    always_comb begin
        alu_ctl_d   = alu_ctl_q;
        ctl_last_d  = ctl_last_q;
        remaining_d = remaining_q;
        illegal_d   = accept && !dec_legal;
        if (accept && dec_legal) begin
            alu_ctl_d   = CTL_W'(dec_ctl);
            remaining_d = req_beats;
            ctl_last_d  = (req_beats == SHAMT_W'(1));
        end else if (handshake) begin
            if (ctl_last_q) begin
                ctl_last_d  = 1'b0;
                remaining_d = '0;
            end else begin
                remaining_d = remaining_q - SHAMT_W'(1);
                ctl_last_d  = (remaining_q == SHAMT_W'(2));
            end
        end
    end

endmodule

// File: tb/tb_alu_ctl_sequencer.sv
// Self-checking bench for alu_ctl_sequencer: directed scenarios plus a
// randomized run scored against a request-to-beat-list reference model.
module tb_alu_ctl_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic [4:0] shamt;
    logic       ctl_valid;
    logic       ctl_ready;
    logic [2:0] alu_ctl;
    logic       ctl_last;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        legal;
        logic [2:0]  ctl;
        int unsigned beats;
    } req_model_t;

    typedef struct packed {
        logic [2:0] ctl;
        logic       last;
    } beat_t;

    alu_ctl_sequencer #(
        .ALU_OP_W (2),
        .FUNCT_W  (6),
        .CTL_W    (3),
        .SHAMT_W  (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .shamt     (shamt),
        .ctl_valid (ctl_valid),
        .ctl_ready (ctl_ready),
        .alu_ctl   (alu_ctl),
        .ctl_last  (ctl_last),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic req_model_t model_decode(input logic [1:0] op, input logic [5:0] f,
                                                input logic [4:0] sh);
        req_model_t r;
        r.legal = 1'b1;
        r.beats = 1;
        r.ctl   = 3'b010;
        if (op[1] == 1'b0) begin
            r.ctl = op[0] ? 3'b110 : 3'b010;
        end else begin
            case (f)
                6'b100000: r.ctl = 3'b010;
                6'b100001: begin r.ctl = 3'b100; r.beats = (sh == 0) ? 1 : int'(sh); end
                6'b100010: r.ctl = 3'b110;
                6'b100011: begin r.ctl = 3'b101; r.beats = (sh == 0) ? 1 : int'(sh); end
                6'b100100: r.ctl = 3'b000;
                6'b100101: r.ctl = 3'b001;
                default:   begin r.legal = 1'b0; r.ctl = 3'b000; end
            endcase
        end
        return r;
    endfunction

    task automatic drive_req(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh);
        alu_op   = op;
        funct    = f;
        shamt    = sh;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; ctl_ready = 1'b0;
        alu_op = '0; funct = '0; shamt = '0;
        #2 rst_n = 1'b0;
        #1;
        total += 5;
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", ctl_valid); end
        if (alu_ctl !== 3'b000) begin bad++; $display("FAIL reset_alu_ctl: got %0b expected 000", alu_ctl); end
        if (ctl_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %0b expected 0", ctl_last); end
        if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %0b expected 0", illegal); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // ROL by 7, abandon after three beats have been consumed
        ctl_ready = 1'b1;
        drive_req(2'b10, 6'b100001, 5'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total += 2;
        if (ctl_valid !== 1'b1) begin bad++; $display("FAIL midrst_beat4_valid: got %0b expected 1", ctl_valid); end
        if (ctl_last !== 1'b0) begin bad++; $display("FAIL midrst_beat4_last: got %0b expected 0", ctl_last); end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b expected 0", ctl_valid); end
        if (ctl_last !== 1'b0) begin bad++; $display("FAIL midrst_last: got %0b expected 0", ctl_last); end
        if (alu_ctl !== 3'b000) begin bad++; $display("FAIL midrst_alu_ctl: got %0b expected 000", alu_ctl); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            total++;
            if (ctl_valid !== 1'b0) begin bad++; $display("FAIL postrst_no_beat: cycle %0d got %0b expected 0", i, ctl_valid); end
        end
    endtask

    task automatic test_single();
        logic [1:0] ops [2];
        req_model_t m;
        ops[0] = 2'b00; ops[1] = 2'b01;
        ctl_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_req(ops[i], 6'($urandom), 5'($urandom));
            m = model_decode(ops[i], funct, shamt);
            #1;
            total += 2;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %0b expected 1", in_ready); end
            if (ctl_valid !== 1'b0) begin bad++; $display("FAIL single_cycleN_valid: got %0b expected 0", ctl_valid); end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            total += 3;
            if (ctl_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b expected 1", ctl_valid); end
            if (alu_ctl !== m.ctl) begin bad++; $display("FAIL single_alu_ctl: got %0b expected %0b", alu_ctl, m.ctl); end
            if (ctl_last !== 1'b1) begin bad++; $display("FAIL single_last: got %0b expected 1", ctl_last); end
            @(negedge clk); #1;
            total++;
            if (ctl_valid !== 1'b0) begin bad++; $display("FAIL single_done: got %0b expected 0", ctl_valid); end
        end
    endtask

    task automatic test_rotate_stream();
        req_model_t m;
        ctl_ready = 1'b1;
        @(negedge clk);
        drive_req(2'b10, 6'b100011, 5'd4);
        m = model_decode(alu_op, funct, shamt);
        @(negedge clk);
        in_valid = 1'b0;
        for (int unsigned k = 1; k <= m.beats; k++) begin
            #1;
            total += 4;
            if (ctl_valid !== 1'b1) begin bad++; $display("FAIL ror_valid: beat %0d got %0b expected 1", k, ctl_valid); end
            if (alu_ctl !== m.ctl) begin bad++; $display("FAIL ror_alu_ctl: beat %0d got %0b expected %0b", k, alu_ctl, m.ctl); end
            if (ctl_last !== (k == m.beats)) begin bad++; $display("FAIL ror_last: beat %0d got %0b expected %0b", k, ctl_last, k == m.beats); end
            if (in_ready !== (k == m.beats)) begin bad++; $display("FAIL ror_in_ready: beat %0d got %0b expected %0b", k, in_ready, k == m.beats); end
            @(negedge clk);
        end
        #1;
        total++;
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL ror_end: got %0b expected 0", ctl_valid); end
    endtask

    task automatic test_stall();
        logic [4:0]  pat;
        int unsigned idx;
        logic        prev_stall;
        logic [2:0]  prev_ctl;
        logic        prev_last;
        req_model_t  m;
        pat = 5'b11001;
        idx = 1;
        prev_stall = 1'b0; prev_ctl = '0; prev_last = 1'b0;
        @(negedge clk);
        drive_req(2'b10, 6'b100001, 5'd3);
        m = model_decode(alu_op, funct, shamt);
        ctl_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ctl_ready = pat[i];
            #1;
            total += 3;
            if (ctl_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: cycle %0d got %0b expected 1", i, ctl_valid); end
            if (alu_ctl !== m.ctl) begin bad++; $display("FAIL stall_alu_ctl: cycle %0d got %0b expected %0b", i, alu_ctl, m.ctl); end
            if (ctl_last !== (idx == m.beats)) begin bad++; $display("FAIL stall_last: cycle %0d got %0b expected %0b", i, ctl_last, idx == m.beats); end
            if (prev_stall) begin
                total++;
                if (alu_ctl !== prev_ctl || ctl_last !== prev_last) begin
                    bad++; $display("FAIL stall_hold: cycle %0d got %0b/%0b expected %0b/%0b", i, alu_ctl, ctl_last, prev_ctl, prev_last);
                end
            end
            prev_stall = !pat[i]; prev_ctl = alu_ctl; prev_last = ctl_last;
            if (pat[i]) idx++;
            @(negedge clk);
        end
        #1;
        total += 2;
        if (idx !== m.beats + 1) begin bad++; $display("FAIL stall_beats: got %0d expected %0d", idx - 1, m.beats); end
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL stall_end: got %0b expected 0", ctl_valid); end
    endtask

    task automatic test_illegal();
        ctl_ready = 1'b1;
        @(negedge clk);
        drive_req(2'b10, 6'b100101, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        drive_req(2'b10, 6'b101010, 5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total += 3;
        if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse: got %0b expected 1", illegal); end
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL illegal_no_beat: got %0b expected 0", ctl_valid); end
        if (alu_ctl !== 3'b001) begin bad++; $display("FAIL illegal_alu_hold: got %0b expected 001", alu_ctl); end
        @(negedge clk); #1;
        total += 2;
        if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_one_cycle: got %0b expected 0", illegal); end
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL illegal_idle: got %0b expected 0", ctl_valid); end
        drive_req(2'b10, 6'b100000, 5'd0);
        @(negedge clk);
        // illegal request presented on the final-beat handshake of the ADD
        drive_req(2'b11, 6'b111111, 5'd2);
        #1;
        total += 3;
        if (ctl_valid !== 1'b1) begin bad++; $display("FAIL illegal_next_add_valid: got %0b expected 1", ctl_valid); end
        if (alu_ctl !== 3'b010) begin bad++; $display("FAIL illegal_next_add_ctl: got %0b expected 010", alu_ctl); end
        if (ctl_last !== 1'b1) begin bad++; $display("FAIL illegal_next_add_last: got %0b expected 1", ctl_last); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total += 2;
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL illegal_end_stream: got %0b expected 0", ctl_valid); end
        if (illegal !== 1'b1) begin bad++; $display("FAIL illegal_on_last: got %0b expected 1", illegal); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [5:0] fl [4];
        req_model_t m [4];
        req_model_t r;
        fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100; fl[3] = 6'b100101;
        for (int i = 0; i < 4; i++) m[i] = model_decode(2'b10, fl[i], 5'd0);
        ctl_ready = 1'b1;
        drive_req(2'b10, fl[0], 5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) drive_req(2'b10, fl[i + 1], 5'($urandom)); else in_valid = 1'b0;
            #1;
            total += 4;
            if (ctl_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: beat %0d got %0b expected 1", i, ctl_valid); end
            if (alu_ctl !== m[i].ctl) begin bad++; $display("FAIL b2b_alu_ctl: beat %0d got %0b expected %0b", i, alu_ctl, m[i].ctl); end
            if (ctl_last !== 1'b1) begin bad++; $display("FAIL b2b_last: beat %0d got %0b expected 1", i, ctl_last); end
            if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: beat %0d got %0b expected 1", i, in_ready); end
        end
        @(negedge clk); #1;
        total++;
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %0b expected 0", ctl_valid); end
        drive_req(2'b10, 6'b100001, 5'd0);
        r = model_decode(alu_op, funct, shamt);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total += 3;
        if (ctl_valid !== 1'b1) begin bad++; $display("FAIL rol0_valid: got %0b expected 1", ctl_valid); end
        if (alu_ctl !== r.ctl) begin bad++; $display("FAIL rol0_alu_ctl: got %0b expected %0b", alu_ctl, r.ctl); end
        if (ctl_last !== (r.beats == 1)) begin bad++; $display("FAIL rol0_last: got %0b expected %0b", ctl_last, r.beats == 1); end
        @(negedge clk); #1;
        total++;
        if (ctl_valid !== 1'b0) begin bad++; $display("FAIL rol0_single_beat: got %0b expected 0", ctl_valid); end
    endtask

    task automatic test_random();
        beat_t      q [$];
        logic       exp_illegal;
        logic       exp_ready;
        logic       next_illegal;
        req_model_t m;
        logic [5:0] fl [6];
        fl[0] = 6'b100000; fl[1] = 6'b100001; fl[2] = 6'b100010;
        fl[3] = 6'b100011; fl[4] = 6'b100100; fl[5] = 6'b100101;
        exp_illegal = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            alu_op    = 2'($urandom_range(0, 3));
            funct     = ($urandom_range(0, 7) < 6) ? fl[$urandom_range(0, 5)] : 6'($urandom);
            shamt     = 5'($urandom_range(0, 6));
            ctl_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (q.size() == 0) || (ctl_ready && q[0].last);
            total += 3;
            if (ctl_valid !== (q.size() != 0)) begin bad++; $display("FAIL rand_valid: cycle %0d got %0b expected %0b", cyc, ctl_valid, q.size() != 0); end
            if (in_ready !== exp_ready) begin bad++; $display("FAIL rand_in_ready: cycle %0d got %0b expected %0b", cyc, in_ready, exp_ready); end
            if (illegal !== exp_illegal) begin bad++; $display("FAIL rand_illegal: cycle %0d got %0b expected %0b", cyc, illegal, exp_illegal); end
            if (q.size() != 0) begin
                total += 2;
                if (alu_ctl !== q[0].ctl) begin bad++; $display("FAIL rand_alu_ctl: cycle %0d got %0b expected %0b", cyc, alu_ctl, q[0].ctl); end
                if (ctl_last !== q[0].last) begin bad++; $display("FAIL rand_last: cycle %0d got %0b expected %0b", cyc, ctl_last, q[0].last); end
                if (ctl_ready) void'(q.pop_front());
            end
            next_illegal = 1'b0;
            if (in_valid && exp_ready) begin
                m = model_decode(alu_op, funct, shamt);
                if (m.legal) begin
                    for (int unsigned b = 1; b <= m.beats; b++) q.push_back('{ctl: m.ctl, last: (b == m.beats)});
                end else begin
                    next_illegal = 1'b1;
                end
            end
            exp_illegal = next_illegal;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate_stream();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
